serial_adder: RTL and testbench

//  Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus a carry flip-flop.

---
 rtl/serial_adder.sv | 112 +++++++++++
 tb/tb_serial_adder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: a single full-adder cell and a carry flop
// consume one operand bit per clock, LSB first, behind a start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH  = 8,
    parameter bit SUB_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic             do_sub;
    logic             s_bit;
    logic             carry_next;
    logic [WIDTH-1:0] sum_next;

    assign do_sub     = sub & SUB_EN;
    assign s_bit      = a_reg[0] ^ b_reg[0] ^ carry_reg;
    assign carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);

    // New result bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_next = s_bit;
        end else begin : g_sum_wn
            assign sum_next = {s_bit, sum_reg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
                        a_reg     <= a;
                        b_reg     <= do_sub ? ~b : b;
                        carry_reg <= do_sub ? 1'b1 : cin;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    carry_reg <= carry_next;
                    sum_reg   <= sum_next;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        // carry_reg here is the carry into the MSB.
                        cout_reg  <= carry_next;
                        ovf_reg   <= carry_reg ^ carry_next;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized bench for serial_adder: 8-bit add/sub, 8-bit add-only,
// and an exhaustive 4-bit instance, all against an arithmetic reference model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       cin, sub;

    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
    logic       busyn, donen, coutn, ovfn;
    logic [7:0] sumn;

    logic       start4, cin4, sub4;
    logic [3:0] a4, b4;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .SUB_EN(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(8), .SUB_EN(1'b0)) dut_nosub (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busyn), .done(donen), .sum(sumn), .cout(coutn), .ovf(ovfn)
    );

    serial_adder #(.WIDTH(4), .SUB_EN(1'b1)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    // Reference: {ovf, cout, sum} from plain integer arithmetic at width w.
    function automatic logic [9:0] model(input int w, input bit sub_en, input logic [7:0] x,
                                         input logic [7:0] y, input logic ci, input logic s);
        logic [7:0] mask;
        logic [7:0] bb;
        logic [7:0] res;
        logic       c0;
        logic       co;
        logic       ov;
        bit         es;
        int         total;
        mask  = 8'hFF >> (8 - w);
        es    = s & sub_en;
        bb    = (es ? ~y : y) & mask;
        c0    = es ? 1'b1 : ci;
        total = int'(x & mask) + int'(bb) + int'(c0);
        res   = total[7:0] & mask;
        co    = total[w];
        ov    = (x[w-1] == bb[w-1]) && (res[w-1] != x[w-1]);
        return {ov, co, res};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s);
        @(negedge clk);
        a = x; b = y; cin = c; sub = s; start = 1'b1;
    endtask

    // Called with start already asserted; optionally pokes start mid-run
    // (intrude>0) and optionally launches a new op in the done cycle (chain).
    task automatic wait_result(input logic [7:0] ea, input logic [7:0] eb, input logic ec,
                               input logic es, input int intrude, input bit chain,
                               input logic [7:0] na, input logic [7:0] nb);
        logic [9:0] e8;
        logic [9:0] en;
        int         lat;
        bit         seen;
        e8 = model(8, 1'b1, ea, eb, ec, es);
        en = model(8, 1'b0, ea, eb, ec, es);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy8, 1);
        check("done_after_start", done8, 0);
        lat  = 0;
        seen = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == intrude) begin
                start = 1'b1; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end else if (lat == intrude + 1) begin
                start = 1'b0;
            end
            if (done8) seen = 1;
            else       check("busy_run", busy8, 1);
        end
        check("done_seen", seen, 1);
        check("latency", lat, 8);
        check("busy_at_done", busy8, 0);
        check("sum", sum8, e8[7:0]);
        check("cout", cout8, e8[8]);
        check("ovf", ovf8, e8[9]);
        check("nosub_done", donen, 1);
        check("nosub_sum", sumn, en[7:0]);
        check("nosub_cout", coutn, en[8]);
        check("nosub_ovf", ovfn, en[9]);
        $display("op a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d ovf=%0d (nosub sum=%02h)",
                 ea, eb, ec, es, sum8, cout8, ovf8, sumn);
        if (chain) begin
            a = na; b = nb; cin = 1'b0; sub = 1'b0; start = 1'b1;
        end else begin
            @(negedge clk);
            check("done_one_cycle", done8, 0);
            @(negedge clk);
            check("hold_sum", sum8, e8[7:0]);
        end
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic c, input logic s);
        logic [9:0] e;
        int         lat;
        int         dones;
        e = model(4, 1'b1, {4'h0, x}, {4'h0, y}, c, s);
        @(negedge clk);
        a4 = x; b4 = y; cin4 = c; sub4 = s; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat   = 0;
        dones = 0;
        while (dones == 0 && lat < 12) begin
            @(negedge clk);
            lat++;
            if (done4) dones++;
        end
        check("w4_latency", lat, 4);
        check("w4_result", {ovf4, cout4, sum4}, {e[9:8], e[3:0]});
        @(negedge clk);
        check("w4_done_once", done4, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_sum", sum8, 0);
        check("rst_cout", cout8, 0);
        check("rst_ovf", ovf8, 0);
        rst_n = 1'b1;

        start_op(8'h00, 8'h00, 1'b0, 1'b0); wait_result(8'h00, 8'h00, 1'b0, 1'b0, 0, 0, 0, 0);
        start_op(8'hFF, 8'h01, 1'b0, 1'b0); wait_result(8'hFF, 8'h01, 1'b0, 1'b0, 0, 0, 0, 0);
        start_op(8'h7F, 8'h01, 1'b0, 1'b0); wait_result(8'h7F, 8'h01, 1'b0, 1'b0, 0, 0, 0, 0);
        start_op(8'h05, 8'h07, 1'b0, 1'b1); wait_result(8'h05, 8'h07, 1'b0, 1'b1, 0, 0, 0, 0);
        start_op(8'h80, 8'h01, 1'b0, 1'b1); wait_result(8'h80, 8'h01, 1'b0, 1'b1, 0, 0, 0, 0);

        // Start mid-run is ignored; start in the done cycle is accepted.
        start_op(8'h12, 8'h34, 1'b1, 1'b0);
        wait_result(8'h12, 8'h34, 1'b1, 1'b0, 3, 1, 8'h01, 8'h02);
        wait_result(8'h01, 8'h02, 1'b0, 1'b0, 0, 0, 0, 0);

        // Reset after four bits: outputs clear immediately and no done follows.
        start_op(8'h55, 8'h66, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy8, 0);
        check("midrst_done", done8, 0);
        check("midrst_sum", sum8, 0);
        check("midrst_cout", cout8, 0);
        check("midrst_ovf", ovf8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("midrst_no_done", done8, 0);
        end
        start_op(8'h10, 8'h20, 1'b0, 1'b0); wait_result(8'h10, 8'h20, 1'b0, 1'b0, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] x, y;
            logic       c, s;
            int         intr;
            x    = 8'($urandom);
            y    = 8'($urandom);
            c    = 1'($urandom);
            s    = 1'($urandom);
            intr = int'($urandom_range(0, 6));
            start_op(x, y, c, s);
            wait_result(x, y, c, s, intr, 0, 0, 0);
        end

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int m = 0; m < 4; m++) begin
                    op4(4'(ai), 4'(bi), m[0], m[1]);
                end
            end
        end
        $display("w4 exhaustive sweep complete");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
